vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port framebuffer RAM between the display fetch path and a write requester.
//  Sits between the VGA timing generator (next_x/next_y/disp_en, 1024x768) and the BRAM.
//  Display reads have absolute priority, so scan-out never starves.
//  Writers get all remaining port slots through a valid/ready handshake.
// PARAMETERS
//  SCALE_LOG2  2    screen px per fb px = 2**SCALE_LOG2 per axis (fb 256x192 at default)
//  FB_W        256  framebuffer width in fb pixels (1024 >> SCALE_LOG2)
//  FB_H        192  framebuffer height in fb pixels (768 >> SCALE_LOG2)
//  DATA_W      12   pixel word width (4:4:4 RGB)
//  ADDR_W      16   RAM address width; must satisfy 2**ADDR_W >= FB_W*FB_H
//  RD_LAT      1    RAM read latency in cycles (1..3)
// PORTS
//  i_clk          in   1       pixel clock (same domain as the VGA timing generator)
//  i_rst_n        in   1       asynchronous active-low reset
//  i_next_x       in   11      next screen x from the timing generator
//  i_next_y       in   10      next screen y from the timing generator
//  i_disp_en      in   1       next pixel lies in the visible area
//  i_frame_start  in   1       one-cycle pulse at x=0, y=0
//  o_pix_data     out  DATA_W  fetched pixel, held until the next fetch returns
//  o_pix_valid    out  1       o_pix_data belongs to the current visible fb pixel
//  i_wr_valid     in   1       write request
//  o_wr_ready     out  1       write accepted this cycle when i_wr_valid=1
//  i_wr_addr      in   ADDR_W  write address (linear, y*FB_W+x)
//  i_wr_data      in   DATA_W  write data
//  o_ram_en       out  1       RAM port enable
//  o_ram_we       out  1       RAM write enable
//  o_ram_addr     out  ADDR_W  RAM address
//  o_ram_wdata    out  DATA_W  RAM write data
//  i_ram_rdata    in   DATA_W  RAM read data, valid RD_LAT cycles after the read cycle
// BEHAVIOUR
//  - Read slot (rd_req): i_disp_en=1 and i_next_x[SCALE_LOG2-1:0]==0.
//    Address = (i_next_y>>SCALE_LOG2)*FB_W + (i_next_x>>SCALE_LOG2).
//  - Port mux is combinational and priority-ordered:
//    - rd_req=1: en=1, we=0, addr=read address; o_wr_ready=0.
//    - else i_wr_valid=1: en=1, we=1, addr/wdata from the write port; o_wr_ready=1.
//    - else: en=0, we=0; o_wr_ready=1.
//  - o_wr_ready never depends on i_wr_valid.
//  - Writer must hold addr/data/valid stable until accepted.
//  - Read pipeline: shift register rd_pipe[RD_LAT] records issued reads.
//    When rd_pipe[RD_LAT-1]=1, o_pix_data <= i_ram_rdata and o_pix_valid <= 1.
//    At default params, data for fb px at next_x=N is registered at cycle N+RD_LAT+1.
//  - o_pix_valid <= 0 on the first cycle i_disp_en=0. It stays 0 until the next read returns.
//  - o_pix_data is unchanged when o_pix_valid drops.
//  - Blanking: no reads; every cycle is a write slot.
//  - In-display write throughput: (2**SCALE_LOG2 - 1) of every 2**SCALE_LOG2 cycles.
//  - Same-address read and write in the same cycle cannot occur (the read wins the port).
//  - Write to a pixel currently on screen: the new value appears from the next frame or next fetch.
//  - Addresses >= FB_W*FB_H are passed through unchecked. The writer owns range checking.
//  - Reset (any time, incl. mid-read): rd_pipe cleared, o_pix_data=0, o_pix_valid=0.
//    Reset drives o_ram_en=0, o_ram_we=0 and o_wr_ready=0 while i_rst_n=0.
//    In-flight RAM data after reset release is discarded.
//  - i_frame_start: clears rd_pipe and o_pix_valid (resynchronises the fetch phase).
//    Does not block writes.
// CONFIGURATION
//  - FB_STALL_CNT_EN defined: adds port o_stall_cnt (out, 16), a saturating count of cycles with
//    i_wr_valid=1 and o_wr_ready=0.
//    - Cleared to 0 on i_frame_start and on reset.
//    - Holds at 16'hFFFF.
//    - Same-cycle frame_start and stall: cleared to 0 (clear wins).
//  - FB_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package vga_fb_pkg holds:
//    - FB_W, FB_H, SCALE_LOG2, DATA_W, ADDR_W defaults.
//    - The 1024x768 visible-area constants.
//    - Function fb_addr(x,y) for the linear address.
//  - Sub-module vga_fb_addr_gen: screen x/y + disp_en -> rd_req and read address (combinational).
//  - The arbiter keeps the port mux, read pipeline and stall counter.
// TESTING
//  - Reset held, i_wr_valid=1:
//    o_ram_en=0, o_wr_ready=0, o_pix_valid=0, o_pix_data=0.
//  - Blanking (i_disp_en=0), 100 back-to-back writes:
//    100 consecutive accepts; each RAM write has the matching addr/data.
//  - Display line y=8, continuous i_wr_valid:
//    o_wr_ready=0 exactly at x%4==0; read address=2*256+x/4.
//    Writes accepted on the other 3 of every 4 cycles.
//  - RAM model preloaded addr=k with data=k[11:0], RD_LAT=1 and 3:
//    o_pix_data=expected fb word RD_LAT+1 cycles after each read; o_pix_valid high across the line.
//    o_pix_valid drops the first cycle after i_disp_en falls.
//  - Assert i_rst_n=0 one cycle after a read issue:
//    no o_pix_valid pulse after release; the next read at the following group behaves normally.
//  - FB_STALL_CNT_EN, one full display line with writer always valid:
//    o_stall_cnt=256 (one stall per read slot on a 1024-px line, FB_W=256).
//    Clears to 0 on i_frame_start; saturates at 16'hFFFF under forced stall.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants and helpers for the VGA framebuffer arbiter.
// Screen geometry is fixed at 1024x768 visible.
package vga_fb_pkg;

  localparam int H_VIS = 1024;
  localparam int V_VIS = 768;
  localparam int X_W   = 11;
  localparam int Y_W   = 10;

  localparam int SCALE_LOG2_D = 2;
  localparam int FB_W_D       = H_VIS >> SCALE_LOG2_D;
  localparam int FB_H_D       = V_VIS >> SCALE_LOG2_D;
  localparam int DATA_W_D     = 12;
  localparam int ADDR_W_D     = 16;

  function automatic logic [31:0] fb_addr(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] w
  );
    return y * w + x;
  endfunction

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Maps the timing generator's next screen position to a fetch request
// and the linear framebuffer address of the covering fb pixel.
module vga_fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int SCALE_LOG2 = SCALE_LOG2_D,
  parameter int FB_W       = FB_W_D,
  parameter int ADDR_W     = ADDR_W_D
) (
  input  logic [X_W-1:0]    next_x,
  input  logic [Y_W-1:0]    next_y,
  input  logic              disp_en,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr
);

  logic [31:0] fx;
  logic [31:0] fy;

  // One fetch per fb pixel, on the first screen column it covers
  always_comb begin
    fx      = 32'(next_x >> SCALE_LOG2);
    fy      = 32'(next_y >> SCALE_LOG2);
    rd_req  = disp_en && (next_x[SCALE_LOG2-1:0] == '0);
    rd_addr = ADDR_W'(fb_addr(fx, fy, 32'(FB_W)));
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch has priority, writer
// takes the remaining slots. Optional stall counter: FB_STALL_CNT_EN.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int SCALE_LOG2 = SCALE_LOG2_D,
  parameter int FB_W       = FB_W_D,
  parameter int FB_H       = FB_H_D,
  parameter int DATA_W     = DATA_W_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int RD_LAT     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [X_W-1:0]    i_next_x,
  input  logic [Y_W-1:0]    i_next_y,
  input  logic              i_disp_en,
  input  logic              i_frame_start,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
`ifdef FB_STALL_CNT_EN
  ,
  output logic [15:0]       o_stall_cnt
`endif
);

  if ((64'(1) << ADDR_W) < 64'(FB_W) * 64'(FB_H)) begin : g_addr_chk
    $error("ADDR_W too small for FB_W*FB_H");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_chk
    $error("RD_LAT must be 1..3");
  end

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT-1:0] rd_pipe;

  vga_fb_addr_gen #(
    .SCALE_LOG2(SCALE_LOG2),
    .FB_W      (FB_W),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .next_x (i_next_x),
    .next_y (i_next_y),
    .disp_en(i_disp_en),
    .rd_req (rd_req),
    .rd_addr(rd_addr)
  );

  // Port mux: reset idles the port, then read beats write
  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = i_wr_addr;
    o_ram_wdata = i_wr_data;
    o_wr_ready  = 1'b0;
    if (!i_rst_n) begin
      o_wr_ready = 1'b0;
    end else if (rd_req) begin
      o_ram_en   = 1'b1;
      o_ram_addr = rd_addr;
    end else begin
      o_wr_ready = 1'b1;
      o_ram_en   = i_wr_valid;
      o_ram_we   = i_wr_valid;
    end
  end

  // Track issued reads; frame start drops stale ones but keeps a read
  // issued in the same cycle so the frame's first pixel is not lost
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_pipe <= '0;
    end else if (i_frame_start) begin
      rd_pipe <= RD_LAT'(rd_req);
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_req);
    end
  end

  // Capture returning pixel; valid drops in blanking, data holds
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_data  <= '0;
      o_pix_valid <= 1'b0;
    end else if (i_frame_start) begin
      o_pix_valid <= 1'b0;
    end else if (rd_pipe[RD_LAT-1]) begin
      o_pix_data  <= i_ram_rdata;
      o_pix_valid <= 1'b1;
    end else if (!i_disp_en) begin
      o_pix_valid <= 1'b0;
    end
  end

`ifdef FB_STALL_CNT_EN
  // Saturating count of writer stalls; frame start clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
    end else if (i_frame_start) begin
      o_stall_cnt <= '0;
    end else if (i_wr_valid && !o_wr_ready &&
                 o_stall_cnt != 16'hFFFF) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter, RD_LAT=1 and RD_LAT=3 side by side.
// Behavioural RAMs preloaded with mem[k] = k[11:0].
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [10:0] nx;
  logic [9:0]  ny;
  logic        den, fs, wv;
  logic [15:0] wa;
  logic [11:0] wd;

  logic [11:0] pd1, pd3, wdat1, wdat3, rdat1, rdat3;
  logic        pv1, pv3, rdy1, rdy3, en1, en3, we1, we3;
  logic [15:0] addr1, addr3;
`ifdef FB_STALL_CNT_EN
  logic [15:0] stall1, stall3;
`endif

  vga_fb_arbiter #(.RD_LAT(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_next_x(nx), .i_next_y(ny),
    .i_disp_en(den), .i_frame_start(fs),
    .o_pix_data(pd1), .o_pix_valid(pv1),
    .i_wr_valid(wv), .o_wr_ready(rdy1),
    .i_wr_addr(wa), .i_wr_data(wd),
    .o_ram_en(en1), .o_ram_we(we1),
    .o_ram_addr(addr1), .o_ram_wdata(wdat1),
    .i_ram_rdata(rdat1)
`ifdef FB_STALL_CNT_EN
    , .o_stall_cnt(stall1)
`endif
  );

  vga_fb_arbiter #(.RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_next_x(nx), .i_next_y(ny),
    .i_disp_en(den), .i_frame_start(fs),
    .o_pix_data(pd3), .o_pix_valid(pv3),
    .i_wr_valid(wv), .o_wr_ready(rdy3),
    .i_wr_addr(wa), .i_wr_data(wd),
    .o_ram_en(en3), .o_ram_we(we3),
    .o_ram_addr(addr3), .o_ram_wdata(wdat3),
    .i_ram_rdata(rdat3)
`ifdef FB_STALL_CNT_EN
    , .o_stall_cnt(stall3)
`endif
  );

  logic [11:0] mem1 [65536];
  logic [11:0] mem3 [65536];
  logic [11:0] q1, q3a, q3b, q3c;

  always @(posedge clk) begin
    if (en1 && we1) mem1[addr1] <= wdat1;
    if (en1 && !we1) q1 <= mem1[addr1];
    if (en3 && we3) mem3[addr3] <= wdat3;
    if (en3 && !we3) q3a <= mem3[addr3];
    q3b <= q3a;
    q3c <= q3b;
  end
  assign rdat1 = q1;
  assign rdat3 = q3c;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input int x, input int y,
                       input logic e, input logic f, input logic v,
                       input int a, input int d);
    rst_n = r;
    nx    = 11'(x);
    ny    = 10'(y);
    den   = e;
    fs    = f;
    wv    = v;
    wa    = 16'(a);
    wd    = 12'(d);
    #4;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fbw(input int k);
    return 32'(k % 4096);
  endfunction

  typedef struct {
    logic rst;
    int   x;
    int   y;
    logic den;
    logic wv;
    int   wa;
    int   wd;
    logic e_en;
    logic e_we;
    int   e_addr;
    int   e_wd;
    logic e_rdy;
    logic ck_addr;
  } vec_t;

  vec_t tv[9];
  int   acc;
  int   n;

  initial begin
    for (int k = 0; k < 65536; k++) begin
      mem1[k] = 12'(k);
      mem3[k] = 12'(k);
    end
    q1 = '0; q3a = '0; q3b = '0; q3c = '0;

    tv[0] = '{1'b0, 0,    0,   1'b1, 1'b1, 'h55,   'h66,
              1'b0, 1'b0, 0,      0,     1'b0, 1'b0};
    tv[1] = '{1'b1, 4,    8,   1'b1, 1'b1, 'h1234, 'hABC,
              1'b1, 1'b0, 'h0201, 0,     1'b0, 1'b1};
    tv[2] = '{1'b1, 5,    8,   1'b1, 1'b1, 'h1234, 'hABC,
              1'b1, 1'b1, 'h1234, 'hABC, 1'b1, 1'b1};
    tv[3] = '{1'b1, 5,    8,   1'b1, 1'b0, 'h1234, 'hABC,
              1'b0, 1'b0, 0,      0,     1'b1, 1'b0};
    tv[4] = '{1'b1, 0,    0,   1'b0, 1'b1, 'h0050, 'h321,
              1'b1, 1'b1, 'h0050, 'h321, 1'b1, 1'b1};
    tv[5] = '{1'b1, 1020, 767, 1'b1, 1'b0, 0,      0,
              1'b1, 1'b0, 'hBFFF, 0,     1'b0, 1'b1};
    tv[6] = '{1'b1, 8,    767, 1'b1, 1'b1, 'h0077, 'h111,
              1'b1, 1'b0, 'hBF02, 0,     1'b0, 1'b1};
    tv[7] = '{1'b1, 3,    3,   1'b1, 1'b1, 'hFFFF, 'hFFF,
              1'b1, 1'b1, 'hFFFF, 'hFFF, 1'b1, 1'b1};
    tv[8] = '{1'b1, 12,   0,   1'b0, 1'b0, 0,      0,
              1'b0, 1'b0, 0,      0,     1'b1, 1'b0};

    // reset held with a pending write
    nxt();
    drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 'h55, 'h66);
    nxt();
    drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 'h55, 'h66);
    chk("rst_ram_en", 32'(en1), 0);
    chk("rst_ram_we", 32'(we1), 0);
    chk("rst_wr_ready", 32'(rdy1), 0);
    chk("rst_pix_valid1", 32'(pv1), 0);
    chk("rst_pix_data1", 32'(pd1), 0);
    chk("rst_pix_valid3", 32'(pv3), 0);
    chk("rst_pix_data3", 32'(pd3), 0);
    nxt();

    // combinational port mux vectors
    for (int i = 0; i < 9; i++) begin
      drive(tv[i].rst, tv[i].x, tv[i].y, tv[i].den, 1'b0,
            tv[i].wv, tv[i].wa, tv[i].wd);
      chk($sformatf("vec%0d_en", i), 32'(en1), 32'(tv[i].e_en));
      chk($sformatf("vec%0d_we", i), 32'(we1), 32'(tv[i].e_we));
      chk($sformatf("vec%0d_rdy", i), 32'(rdy1), 32'(tv[i].e_rdy));
      if (tv[i].ck_addr)
        chk($sformatf("vec%0d_addr", i), 32'(addr1), tv[i].e_addr);
      if (tv[i].e_we)
        chk($sformatf("vec%0d_wdata", i), 32'(wdat1), tv[i].e_wd);
      nxt();
    end

    // blanking: 100 back-to-back writes
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1100, 0, 1'b0, 1'b0, 1'b1, 100 + i, (i * 37) % 4096);
      chk("blank_rdy", 32'(rdy1), 1);
      chk("blank_we", 32'(we1 & en1), 1);
      chk("blank_addr", 32'(addr1), 32'(100 + i));
      chk("blank_wdata", 32'(wdat1), 32'((i * 37) % 4096));
      if (rdy1 && wv) acc++;
      nxt();
    end
    chk("blank_accepts", 32'(acc), 100);

    drive(1'b1, 1100, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    nxt();

    // display line y=8 with a writer that is always valid
    acc = 0;
    for (int x = 0; x < 1024; x++) begin
      drive(1'b1, x, 8, 1'b1, 1'b0, 1'b1, 'hC000 + x, x % 4096);
      chk("line_rdy", 32'(rdy1), 32'(x % 4 != 0));
      if (x % 4 == 0) begin
        chk("line_rd_addr", 32'(addr1), 32'(512 + x / 4));
        chk("line_rd_we", 32'(we1), 0);
      end else begin
        chk("line_wr_addr", 32'(addr1), 32'('hC000 + x));
      end
      if (rdy1 && wv) acc++;
      nxt();
    end
    chk("line_accepts", 32'(acc), 768);

    drive(1'b1, 1024, 8, 1'b0, 1'b0, 1'b0, 0, 0);
`ifdef FB_STALL_CNT_EN
    chk("stall_line", 32'(stall1), 256);
`endif
    nxt();
    drive(1'b1, 1025, 8, 1'b0, 1'b1, 1'b0, 0, 0);
    nxt();
    drive(1'b1, 1026, 8, 1'b0, 1'b0, 1'b0, 0, 0);
`ifdef FB_STALL_CNT_EN
    chk("stall_clear", 32'(stall1), 0);
`endif
    nxt();
`ifdef FB_STALL_CNT_EN
    drive(1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 0, 0);
    nxt();
    drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 0, 0);
    nxt();
    drive(1'b1, 1030, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("stall_clear_wins", 32'(stall1), 0);
    nxt();
`endif

    // pixel fetch across line y=20 (fb row 5)
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1100, 19, 1'b0, 1'b0, 1'b0, 0, 0);
      nxt();
    end
    for (int c = 0; c <= 1025; c++) begin
      drive(1'b1, c, 20, c < 1024, 1'b0, 1'b0, 0, 0);
      if (c == 0) begin
        chk("pix_start_v1", 32'(pv1), 0);
        chk("pix_start_v3", 32'(pv3), 0);
      end
      if (c >= 2 && c <= 1024) begin
        n = ((c - 2) / 4) * 4;
        chk("pix_v1", 32'(pv1), 1);
        chk("pix_d1", 32'(pd1), fbw(1280 + n / 4));
      end
      if (c >= 4 && c <= 1024) begin
        n = ((c - 4) / 4) * 4;
        chk("pix_v3", 32'(pv3), 1);
        chk("pix_d3", 32'(pd3), fbw(1280 + n / 4));
      end
      if (c == 1025) begin
        chk("pix_drop_v1", 32'(pv1), 0);
        chk("pix_drop_v3", 32'(pv3), 0);
        chk("pix_hold_d1", 32'(pd1), fbw(1535));
        chk("pix_hold_d3", 32'(pd3), fbw(1535));
      end
      nxt();
    end

    // frame_start mid-line drops valid but lets the write through
    for (int c = 0; c <= 12; c++) begin
      drive(1'b1, c, 20, 1'b1, c == 6, c == 6, 'hD000, 'h123);
      if (c == 6) begin
        chk("fs_wr_rdy", 32'(rdy1), 1);
        chk("fs_wr_we", 32'(we1), 1);
      end
      if (c == 7) begin
        chk("fs_v1", 32'(pv1), 0);
        chk("fs_v3", 32'(pv3), 0);
      end
      if (c == 10) begin
        chk("fs_resume_v1", 32'(pv1), 1);
        chk("fs_resume_d1", 32'(pd1), fbw(1282));
      end
      if (c == 11) chk("fs_hold_v3", 32'(pv3), 0);
      if (c == 12) begin
        chk("fs_resume_v3", 32'(pv3), 1);
        chk("fs_resume_d3", 32'(pd3), fbw(1282));
      end
      nxt();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1100, 20, 1'b0, 1'b0, 1'b0, 0, 0);
      nxt();
    end

    // reset asserted one cycle after the read at x=8
    for (int c = 0; c <= 16; c++) begin
      drive(c != 9, c, 20, 1'b1, 1'b0, c == 9, 'hD001, 'h222);
      if (c == 9) begin
        chk("mid_rst_en", 32'(en1), 0);
        chk("mid_rst_rdy", 32'(rdy1), 0);
        chk("mid_rst_d1", 32'(pd1), 0);
        chk("mid_rst_v1", 32'(pv1), 0);
        chk("mid_rst_v3", 32'(pv3), 0);
      end
      if (c >= 10 && c <= 13) chk("post_rst_v1", 32'(pv1), 0);
      if (c >= 10 && c <= 15) chk("post_rst_v3", 32'(pv3), 0);
      if (c == 14) begin
        chk("post_rst_rd_v1", 32'(pv1), 1);
        chk("post_rst_rd_d1", 32'(pd1), fbw(1283));
      end
      if (c == 16) begin
        chk("post_rst_rd_v3", 32'(pv3), 1);
        chk("post_rst_rd_d3", 32'(pd3), fbw(1283));
      end
      nxt();
    end

`ifdef FB_STALL_CNT_EN
    // forced stall long enough to saturate
    for (int c = 0; c < 65540; c++) begin
      drive(1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 0, 0);
      nxt();
    end
    drive(1'b1, 1100, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("stall_sat", 32'(stall1), 32'hFFFF);
    nxt();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
